vc_arbiter: RTL
===============

VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter DATA_W, default 6: width of every data word; bit DATA_W-1 selects the destination (0 = D0, 1 = D1).
REQ-002 Parameter W0, default 3: maximum consecutive VC0 grants while VC1 is eligible.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 active_in  input  1  high = arbitration enabled; driven by the link-state controller's active indication.
REQ-006 vc0_empty, vc1_empty  input  1 each  the VC FIFO holds no word.
REQ-007 vc0_data, vc1_data  input  DATA_W each  show-ahead head word of each VC FIFO, valid whenever the FIFO is not empty.
REQ-008 d0_afull, d1_afull  input  1 each  the destination FIFO is almost full.
REQ-009 vc0_pop, vc1_pop  output  1 each  combinational pop strobe to the VC FIFO.
REQ-010 d0_push, d1_push  output  1 each  registered push strobe to the destination FIFO.
REQ-011 d0_data, d1_data  output  DATA_W each  registered word presented with the matching push.
REQ-012 busy  output  1  registered; high in any cycle following a grant.

Function
REQ-013 VCx shall be eligible iff active_in=1, vcx_empty=0, and the afull flag of the destination selected by vcx_data[DATA_W-1] is 0.
REQ-014 At most one pop shall be asserted per cycle; a pop shall be asserted only for an eligible VC.
REQ-015 Grant rule: if only one VC is eligible, that VC is granted; if both are eligible, VC0 is granted when cnt<W0, otherwise VC1.
REQ-016 cnt (counter 0..W0) shall increment, saturating at W0, on each VC0 grant and clear to 0 on each VC1 grant; with no grant it holds its value.
REQ-017 Head-of-line isolation: a VC blocked by afull on its destination shall not block the other VC.
REQ-018 Latency: a word popped in cycle N shall appear on dX_data with dX_push=1 in cycle N+1; throughput shall be one word per cycle.
REQ-019 dX_push shall be 0 in every cycle not preceded by a grant routed to X; d0_push and d1_push shall never be high together.
REQ-020 dX_data shall hold its last value when dX_push=0.
REQ-021 FSM states: IDLE (no grant last cycle), G0 (VC0 granted last cycle), G1 (VC1 granted last cycle); next state = G0/G1 on the respective grant, IDLE on no grant; busy=1 in G0/G1.
REQ-022 Deassertion of active_in shall stop new pops in the same cycle; a push already registered shall still complete.
REQ-023 Both VCs empty, or both destinations afull, shall produce no pop, and the FSM shall move to IDLE.
REQ-024 Because of the one-cycle push delay, the destination FIFO afull threshold shall leave at least one free entry; the block performs no overflow check.

Reset
REQ-025 While reset=1: state=IDLE, cnt=0, d0_push=d1_push=0, d0_data=d1_data=0, busy=0, and vc0_pop=vc1_pop=0 regardless of the other inputs.
REQ-026 A reset asserted mid-operation shall discard any in-flight word; the word is not pushed after reset release.
REQ-027 The first grant after reset release shall occur no earlier than the first rising clk edge on which reset=0.

Structure
REQ-028 The shared interconnect package shall hold the state encodings (IDLE, G0, G1), the DATA_W default and the W0 default.
REQ-029 The block shall be a single module with no sub-module; the FIFOs remain external.

Verification
REQ-030 Reset: assert reset mid-stream with a word in flight -> all outputs 0 asynchronously; no push after release.
REQ-031 VC0 only: 4 words (dest 0) with active_in=1 -> vc0_pop high for 4 cycles, d0_push high in cycles 1-4, data in order.
REQ-032 Weighting: both VCs loaded with 8 words each, W0=3, no afull -> grant pattern 0,0,0,1,0,0,0,1,...
REQ-033 HOL: VC0 head dest 1 with d1_afull=1, VC1 head dest 0 -> only VC1 popped; VC0 popped on the cycle after d1_afull falls.
REQ-034 active_in drops after the 2nd pop of a 5-word burst -> no pops from that cycle on; exactly 2 pushes observed.
REQ-035 Mixed destinations: VC1 words 0x21, 0x05 (DATA_W=6) -> 0x21 on d1_data, 0x05 on d0_data, on consecutive cycles.

Source files
------------

// File: rtl/vc_arbiter_pkg.sv
// Shared interconnect definitions for the VC arbiter: FSM state encodings and
// default datapath/weighting parameters.
package vc_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 6;
  localparam int W0_DEF     = 3;

endpackage

// File: rtl/vc_arbiter.sv
// Two-VC weighted arbiter: combinational pop, one-cycle registered push to the destination
// selected by the word MSB; a VC whose destination is almost full is skipped without blocking the other.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int W0     = W0_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_afull,
  input  logic              d1_afull,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] d0_data,
  output logic [DATA_W-1:0] d1_data,
  output logic              busy
);

  localparam int CNT_W = (W0 < 1) ? 1 : $clog2(W0 + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W0);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              elig0;
  logic              elig1;
  logic              grant0;
  logic              grant1;
  logic              any_grant;
  logic              grant_dest;
  logic [DATA_W-1:0] grant_data;

  // Eligibility looks only at each VC's own head destination, so a blocked VC never stalls the other.
  always_comb begin
    elig0 = active_in && !vc0_empty && !(vc0_data[DATA_W-1] ? d1_afull : d0_afull);
    elig1 = active_in && !vc1_empty && !(vc1_data[DATA_W-1] ? d1_afull : d0_afull);
  end

  // Reset gates the grants so no pop escapes while the block is held in reset.
  always_comb begin
    grant0     = !reset && elig0 && (!elig1 || (cnt_q < CNT_MAX));
    grant1     = !reset && elig1 && !grant0;
    any_grant  = grant0 || grant1;
    grant_data = grant1 ? vc1_data : vc0_data;
    grant_dest = grant_data[DATA_W-1];
  end

  assign vc0_pop = grant0;
  assign vc1_pop = grant1;

  always_comb begin
    state_d = IDLE;
    if (grant0) begin
      state_d = G0;
    end else if (grant1) begin
      state_d = G1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (grant1) begin
      cnt_q <= '0;
    end else if (grant0 && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output words are only loaded on a push, so each destination holds its last word otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0_push <= 1'b0;
      d1_push <= 1'b0;
      d0_data <= '0;
      d1_data <= '0;
    end else begin
      d0_push <= any_grant && !grant_dest;
      d1_push <= any_grant && grant_dest;
      if (any_grant && !grant_dest) begin
        d0_data <= grant_data;
      end
      if (any_grant && grant_dest) begin
        d1_data <= grant_data;
      end
    end
  end

endmodule
